branch_unit: RTL and testbench

Control-flow resolver for the pipelined CPU. It sits in the execute stage and drives the program counter's jump interface (`branch_valid`, `branch_address`). It evaluates jumps, conditional branches, calls and returns, and keeps a hardware return-address stack (RAS). After each redirect it suppresses wrong-path branch requests for a fixed shadow window.

---
 rtl/branch_unit.sv | 175 +++++++++++++++++
 tb/tb_branch_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_unit.sv
// Purpose : execute-stage control-flow resolver (JMP/Bcc/CALL/RET) with a circular return-address stack.
// Latency : request sampled at edge N, redirect pulse and stack update visible in cycle N+1.
// Backpr. : none upstream; after each redirect, br_req is ignored for SHADOW cycles (wrong-path window).
module branch_unit #(
    parameter int ADDR_W    = 11,
    parameter int RAS_DEPTH = 8,
    parameter int SHADOW    = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         br_req,
    input  logic [2:0]                   br_type,
    input  logic [ADDR_W-1:0]            br_pc,
    input  logic [ADDR_W-1:0]            br_imm,
    input  logic                         flag_z,
    input  logic                         flag_n,
    output logic                         branch_valid,
    output logic [ADDR_W-1:0]            branch_address,
    output logic                         flush,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_err
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SHD_W = 3;

    localparam logic [2:0] OP_JMP  = 3'b000;
    localparam logic [2:0] OP_BEQ  = 3'b001;
    localparam logic [2:0] OP_BNE  = 3'b010;
    localparam logic [2:0] OP_BLT  = 3'b011;
    localparam logic [2:0] OP_CALL = 3'b100;
    localparam logic [2:0] OP_RET  = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SHADOW = 1'b1
    } state_t;

    state_t                 state;
    logic [SHD_W-1:0]       shd_cnt;

    // Stack storage: ras_ptr is the next write slot, so the top entry sits at ras_ptr-1.
    // When full, ras_ptr also points at the oldest entry, so a push naturally overwrites it.
    logic [ADDR_W-1:0]      ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]       ras_ptr;
    logic [PTR_W-1:0]       top_ptr;
    logic [ADDR_W-1:0]      tos;
    logic                   ras_empty;
    logic                   ras_full;

    logic                   type_ok;
    logic                   accept;
    logic                   cond_true;
    logic                   taken;
    logic                   do_push;
    logic                   do_pop;
    logic [ADDR_W-1:0]      ret_addr;
    logic [ADDR_W-1:0]      rel_target;
    logic [ADDR_W-1:0]      target;

    // Codes 110/111 are reserved and never accepted; shadow state masks everything.
    assign type_ok = (br_type <= OP_RET);
    assign accept  = br_req && (state == ST_IDLE) && type_ok;

    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));
    assign top_ptr   = ras_ptr - PTR_W'(1);
    assign tos       = ras_mem[top_ptr];

    // Address arithmetic wraps silently at 2^ADDR_W.
    assign ret_addr   = br_pc + ADDR_W'(1);
    assign rel_target = br_pc + ADDR_W'(1) + br_imm;

    // Condition evaluation; unconditional types are always taken.
    always_comb begin
        cond_true = 1'b0;
        case (br_type)
            OP_JMP:  cond_true = 1'b1;
            OP_BEQ:  cond_true = flag_z;
            OP_BNE:  cond_true = !flag_z;
            OP_BLT:  cond_true = flag_n;
            OP_CALL: cond_true = 1'b1;
            OP_RET:  cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    assign taken   = accept && cond_true;
    assign do_push = taken && (br_type == OP_CALL);
    assign do_pop  = taken && (br_type == OP_RET);

    // Redirect target selection; a RET on an empty stack redirects to address 0.
    always_comb begin
        target = '0;
        case (br_type)
            OP_JMP, OP_CALL:        target = br_imm;
            OP_BEQ, OP_BNE, OP_BLT: target = rel_target;
            OP_RET:                 target = ras_empty ? '0 : tos;
            default:                target = '0;
        endcase
    end

    // Control FSM with registered redirect outputs and the shadow countdown.
    // The counter is loaded with SHADOW and the FSM leaves SHADOW on the edge where it reads 1,
    // so the cycle after the last shadow cycle is already IDLE and can accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            shd_cnt        <= '0;
            branch_valid   <= 1'b0;
            branch_address <= '0;
        end else begin
            branch_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (taken) begin
                        branch_valid   <= 1'b1;
                        branch_address <= target;
                        shd_cnt        <= SHD_W'(SHADOW);
                        state          <= ST_SHADOW;
                    end
                end
                ST_SHADOW: begin
                    if (shd_cnt <= SHD_W'(1)) begin
                        shd_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        shd_cnt <= shd_cnt - SHD_W'(1);
                    end
                end
                default: begin
                    shd_cnt <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Stack pointer, occupancy and sticky error; updated on the same edge as the redirect register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ras_ptr   <= '0;
            ras_count <= '0;
            ras_err   <= 1'b0;
        end else begin
            if (do_push) begin
                ras_ptr <= ras_ptr + PTR_W'(1);
                if (ras_full) begin
                    ras_err <= 1'b1;
                end else begin
                    ras_count <= ras_count + CNT_W'(1);
                end
            end else if (do_pop) begin
                if (ras_empty) begin
                    ras_err <= 1'b1;
                end else begin
                    ras_ptr   <= top_ptr;
                    ras_count <= ras_count - CNT_W'(1);
                end
            end
        end
    end

    // Stack contents need no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            ras_mem[ras_ptr] <= ret_addr;
        end
    end

    // Fetch/decode kill follows the redirect pulse exactly.
    assign flush = branch_valid;

endmodule

// File: tb/tb_branch_unit.sv
module tb_branch_unit;

    localparam int ADDR_W = 11;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              reset_n;
    logic              br_req;
    logic [2:0]        br_type;
    logic [ADDR_W-1:0] br_pc;
    logic [ADDR_W-1:0] br_imm;
    logic              flag_z;
    logic              flag_n;
    logic              branch_valid;
    logic [ADDR_W-1:0] branch_address;
    logic              flush;
    logic [CNT_W-1:0]  ras_count;
    logic              ras_err;

    int total = 0;
    int bad   = 0;

    branch_unit #(.ADDR_W(ADDR_W), .RAS_DEPTH(8), .SHADOW(2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .br_req         (br_req),
        .br_type        (br_type),
        .br_pc          (br_pc),
        .br_imm         (br_imm),
        .flag_z         (flag_z),
        .flag_n         (flag_n),
        .branch_valid   (branch_valid),
        .branch_address (branch_address),
        .flush          (flush),
        .ras_count      (ras_count),
        .ras_err        (ras_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one request for one cycle; returns #1 after the sampling edge.
    task automatic issue(input logic [2:0] t, input logic [10:0] pc, input logic [10:0] imm,
                         input logic z, input logic n);
        br_req  = 1'b1;
        br_type = t;
        br_pc   = pc;
        br_imm  = imm;
        flag_z  = z;
        flag_n  = n;
        @(posedge clk);
        #1;
        br_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_pulse(input string tag, input logic [10:0] addr);
        chk({tag, "_valid"}, 32'(branch_valid), 32'd1);
        chk({tag, "_flush"}, 32'(flush), 32'd1);
        chk({tag, "_addr"}, 32'(branch_address), 32'(addr));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, 32'(branch_valid), 32'd0);
        chk({tag, "_flush"}, 32'(flush), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(branch_valid), 32'd0);
        chk({tag, "_flush"}, 32'(flush), 32'd0);
        chk({tag, "_addr"}, 32'(branch_address), 32'd0);
        chk({tag, "_cnt"}, 32'(ras_count), 32'd0);
        chk({tag, "_err"}, 32'(ras_err), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        br_req  = 1'b0;
        br_type = 3'b000;
        br_pc   = '0;
        br_imm  = '0;
        flag_z  = 1'b0;
        flag_n  = 1'b0;

        // Reset state
        idle(3);
        chk_all_zero("in_reset");
        reset_n = 1'b1;
        idle(1);
        chk_all_zero("after_reset");

        // JMP, then shadow suppresses two requests, third is accepted
        issue(3'b000, 11'h000, 11'h155, 1'b0, 1'b0);
        chk_pulse("jmp", 11'h155);
        issue(3'b000, 11'h000, 11'h020, 1'b0, 1'b0);
        chk_quiet("shadow1");
        issue(3'b000, 11'h000, 11'h020, 1'b0, 1'b0);
        chk_quiet("shadow2");
        issue(3'b000, 11'h000, 11'h020, 1'b0, 1'b0);
        chk_pulse("post_shadow_jmp", 11'h020);
        idle(2);

        // Conditional branches
        issue(3'b001, 11'h7FE, 11'h003, 1'b1, 1'b0);
        chk_pulse("beq_wrap", 11'h002);
        idle(2);
        issue(3'b001, 11'h7FE, 11'h003, 1'b0, 1'b0);
        chk_quiet("beq_not_taken");
        issue(3'b000, 11'h000, 11'h0AA, 1'b0, 1'b0);
        chk_pulse("jmp_after_nt", 11'h0AA);
        idle(2);
        issue(3'b010, 11'h050, 11'h010, 1'b0, 1'b0);
        chk_pulse("bne_taken", 11'h061);
        idle(2);
        issue(3'b010, 11'h050, 11'h010, 1'b1, 1'b0);
        chk_quiet("bne_not_taken");
        issue(3'b011, 11'h010, 11'h7FC, 1'b0, 1'b1);
        chk_pulse("blt_neg", 11'h00D);
        idle(2);
        issue(3'b011, 11'h010, 11'h7FC, 1'b1, 1'b0);
        chk_quiet("blt_not_taken");

        // Nested calls and returns
        issue(3'b100, 11'h100, 11'h300, 1'b0, 1'b0);
        chk_pulse("call1", 11'h300);
        chk("call1_cnt", 32'(ras_count), 32'd1);
        idle(2);
        issue(3'b100, 11'h200, 11'h400, 1'b0, 1'b0);
        chk_pulse("call2", 11'h400);
        chk("call2_cnt", 32'(ras_count), 32'd2);
        idle(2);
        issue(3'b101, 11'h410, 11'h000, 1'b0, 1'b0);
        chk_pulse("ret1", 11'h201);
        chk("ret1_cnt", 32'(ras_count), 32'd1);
        idle(2);
        issue(3'b101, 11'h210, 11'h000, 1'b0, 1'b0);
        chk_pulse("ret2", 11'h101);
        chk("ret2_cnt", 32'(ras_count), 32'd0);
        chk("nested_err", 32'(ras_err), 32'd0);
        idle(2);

        // Reserved types: no output, no stack change, FSM stays IDLE
        issue(3'b110, 11'h123, 11'h456, 1'b1, 1'b1);
        chk_quiet("illegal_110");
        chk("illegal_110_cnt", 32'(ras_count), 32'd0);
        issue(3'b111, 11'h123, 11'h456, 1'b1, 1'b1);
        chk_quiet("illegal_111");
        chk("illegal_111_cnt", 32'(ras_count), 32'd0);
        chk("illegal_err", 32'(ras_err), 32'd0);
        issue(3'b000, 11'h000, 11'h3C3, 1'b0, 1'b0);
        chk_pulse("jmp_after_illegal", 11'h3C3);
        idle(2);

        // Overflow: 9 calls into an 8-deep stack
        for (int i = 1; i <= 9; i++) begin
            issue(3'b100, 11'(i), 11'h080, 1'b0, 1'b0);
            chk_pulse($sformatf("ovf_call%0d", i), 11'h080);
            chk($sformatf("ovf_call%0d_cnt", i), 32'(ras_count), (i > 8) ? 32'd8 : 32'(i));
            chk($sformatf("ovf_call%0d_err", i), 32'(ras_err), (i == 9) ? 32'd1 : 32'd0);
            idle(2);
        end
        for (int k = 0; k < 8; k++) begin
            issue(3'b101, 11'h080, 11'h000, 1'b0, 1'b0);
            chk_pulse($sformatf("ovf_ret%0d", k), 11'(10 - k));
            chk($sformatf("ovf_ret%0d_cnt", k), 32'(ras_count), 32'(7 - k));
            idle(2);
        end
        // Underflow
        issue(3'b101, 11'h080, 11'h000, 1'b0, 1'b0);
        chk_pulse("underflow_ret", 11'h000);
        chk("underflow_cnt", 32'(ras_count), 32'd0);
        chk("underflow_err", 32'(ras_err), 32'd1);
        idle(2);

        // Clear sticky error, then reset in the middle of a shadow with 3 entries
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        idle(1);
        chk("err_cleared", 32'(ras_err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            issue(3'b100, 11'(11'h040 + i), 11'h500, 1'b0, 1'b0);
            if (i < 2) idle(2);
        end
        chk_pulse("pre_reset_call", 11'h500);
        chk("pre_reset_cnt", 32'(ras_count), 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        idle(1);
        reset_n = 1'b1;
        issue(3'b101, 11'h500, 11'h000, 1'b0, 1'b0);
        chk_pulse("ret_after_reset", 11'h000);
        chk("ret_after_reset_err", 32'(ras_err), 32'd1);
        chk("ret_after_reset_cnt", 32'(ras_count), 32'd0);
        idle(1);
        chk_quiet("no_back_to_back");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
